zoe_scroller: RTL and testbench
===============================

# zoe_scroller

Parametrised successor to the team's single-glyph seven-segment demo. It stores a message of `MSG_LEN` 4-bit glyph codes and shows one glyph at a time on a seven-segment display. The displayed position advances every `MAX_COUNT` clocks while running, or by single-step when paused. Direction is selectable, and the message can be rewritten at run time. The block sits between the TinyTapeout pin wrapper (`io_in`/`io_out`) and the display pins.

## Interface
- `MAX_COUNT`, 1000: clocks per automatic advance; legal range ≥1.
- `MSG_LEN`, 4: message depth in glyphs; legal range ≥2.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `run` input 1: 1 = auto-advance; 0 = paused.
- `dir` input 1: 0 = index increments; 1 = index decrements.
- `step` input 1: a rising edge advances one position while paused.
- `load` input 1: when high, writes `load_char` into the message.
- `load_char` input 4: glyph code to write.
- `seg` output 7: segment drive, active-high. Bit assignment: [0]=a top, [1]=b upper-right, [2]=c lower-right, [3]=d bottom, [4]=e lower-left, [5]=f upper-left, [6]=g middle.
- `dp` output 1: high while index 0 is displayed (wrap marker).
- `idx` output max(1,$clog2(MSG_LEN)): currently displayed position.

## Operation
- **Glyph codes and `seg` values:**
  - 0 blank 0x00, 1 Z 0x5B, 2 O 0x3F, 3 E 0x79, 4 A 0x77, 5 C 0x39.
  - 6 F 0x71, 7 H 0x76, 8 L 0x38, 9 P 0x73, 10 U 0x3E, 11 dash 0x40.
  - 12–15 are blank (0x00).
- **Message buffer:** `MSG_LEN` entries. Reset contents follow the pattern Z,O,E,blank repeated, so entry i = (1,2,3,0)[i mod 4].
- **Prescaler `cnt`:** range 0..MAX_COUNT-1.
  - While `run`=1: `cnt` increments each clock; when `cnt`==MAX_COUNT-1 it wraps to 0 and raises an internal advance.
  - While `run`=0: `cnt` holds its value, so phase is kept across a pause.
- **Step:** `step_q` is a registered copy of `step`. An advance occurs when `step`=1, `step_q`=0 and `run`=0. While `run`=1, step edges are ignored.
- **Advance:**
  - `dir`=0: `idx` ← (idx+1) mod MSG_LEN, so MSG_LEN-1 wraps to 0.
  - `dir`=1: `idx` ← (idx-1) mod MSG_LEN, so 0 wraps to MSG_LEN-1.
  - `dir` is sampled at the advance edge.
- **Load:**
  - When `load`=1: buf[wr_ptr] ← `load_char` and `wr_ptr` ← (wr_ptr+1) mod MSG_LEN.
  - `wr_ptr` is internal and reset to 0.
  - Consecutive cycles with `load` high write consecutive entries.
- **Simultaneous events:**
  - Load and advance in the same cycle: both take effect.
  - Load into the entry currently displayed: the new glyph appears with normal output latency.
  - Auto-advance and step edge in the same cycle: impossible by construction, since they have mutually exclusive `run` conditions.
- **Output:** each clock, `seg` ← font(buf[idx]) and `dp` ← (idx==0). Both are registered.

## Timing
- **Reset values:** `cnt`=0, `idx`=0, `wr_ptr`=0, buffer = default pattern, `step_q`=1, `seg`=0x00, `dp`=0.
  - `step_q` resets to 1 so that `step` held through reset produces no advance.
- **After reset release:** on the first edge with `reset` low, `seg`=0x5B and `dp`=1.
- **`idx` latency:** `idx` updates on the edge where the advance condition holds.
  - `run`=1: this is the MAX_COUNT-th edge with `run` high after release.
- **`seg`/`dp` latency:** one edge after `idx` (or after a buffer write). Each glyph is displayed for exactly MAX_COUNT clocks under continuous run.
- **MAX_COUNT=1:** advance on every run clock; the counter stays 0.
- **Reset mid-operation:** all state reverts on that edge and loaded message content is lost. `reset` overrides `load`, `run` and `step`.

## Structure
- **Package `zoe_pkg`:**
  - Glyph-code localparams (`GLYPH_BLANK`, `GLYPH_Z`, …).
  - `GLYPH_W`=4.
  - Segment constants.
  - Default-message function.
- **Sub-module `zoe_font`:** purely combinational, 4-bit code in, 7-bit `seg` out. It is instantiated once, ahead of the `seg` register.
- **Counter width:** max(1,$clog2(MAX_COUNT)).

## Test plan
- **Reset and run:** reset 3 cycles, then `run`=1, MAX_COUNT=4, MSG_LEN=4, `dir`=0. Required `seg` sequence: 0x5B ×4, 0x3F ×4, 0x79 ×4, 0x00 ×4, 0x5B. `dp` is high only during the 0x5B periods.
- **Reverse:** `dir`=1 from idx 0 → `idx` goes 3,2,1,0. The first advance shows 0x00 (blank).
- **Pause and step:** `run`=0 mid-count (`cnt`=2), then pulse `step` twice and hold `step` high 10 cycles. Required: exactly 2 advances. After `run`=1, the next advance comes 2 clocks later because `cnt` was held.
- **Load:** `load` high 4 cycles with codes 7,4,8,8 → display cycles H(0x76), A(0x77), L(0x38), L(0x38). Codes 12–15 give 0x00.
- **Simultaneous and reset:**
  - Load into the displayed `idx` while an advance fires → both occur, and the new content shows one cycle later.
  - Assert `reset` with `step` held and `idx`=2 → `idx`=0, message restored, no advance after release.

Source files
------------

// File: rtl/zoe_pkg.sv
// Shared glyph codes, segment patterns and helpers for the zoe scrolling display.
package zoe_pkg;

  localparam int GLYPH_W = 4;
  localparam int SEG_W   = 7;

  typedef logic [GLYPH_W-1:0] glyph_t;
  typedef logic [SEG_W-1:0]   seg_t;

  localparam glyph_t GLYPH_BLANK = 4'd0;
  localparam glyph_t GLYPH_Z     = 4'd1;
  localparam glyph_t GLYPH_O     = 4'd2;
  localparam glyph_t GLYPH_E     = 4'd3;
  localparam glyph_t GLYPH_A     = 4'd4;
  localparam glyph_t GLYPH_C     = 4'd5;
  localparam glyph_t GLYPH_F     = 4'd6;
  localparam glyph_t GLYPH_H     = 4'd7;
  localparam glyph_t GLYPH_L     = 4'd8;
  localparam glyph_t GLYPH_P     = 4'd9;
  localparam glyph_t GLYPH_U     = 4'd10;
  localparam glyph_t GLYPH_DASH  = 4'd11;

  // Bit order is {g,f,e,d,c,b,a}, active-high.
  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_Z     = 7'h5B;
  localparam seg_t SEG_O     = 7'h3F;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_H     = 7'h76;
  localparam seg_t SEG_L     = 7'h38;
  localparam seg_t SEG_P     = 7'h73;
  localparam seg_t SEG_U     = 7'h3E;
  localparam seg_t SEG_DASH  = 7'h40;

  // Width of a counter/pointer covering 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Power-up message: Z,O,E,blank repeating.
  function automatic glyph_t default_glyph(input int i);
    case (i % 4)
      0:       return GLYPH_Z;
      1:       return GLYPH_O;
      2:       return GLYPH_E;
      default: return GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/zoe_font.sv
// Glyph-code to seven-segment decoder; purely combinational.
module zoe_font
  import zoe_pkg::*;
(
  input  logic [GLYPH_W-1:0] code,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    // NOTE: the default arm covers every unlisted code, so no latch is inferred.
    case (code)
      GLYPH_Z:    seg = SEG_Z;
      GLYPH_O:    seg = SEG_O;
      GLYPH_E:    seg = SEG_E;
      GLYPH_A:    seg = SEG_A;
      GLYPH_C:    seg = SEG_C;
      GLYPH_F:    seg = SEG_F;
      GLYPH_H:    seg = SEG_H;
      GLYPH_L:    seg = SEG_L;
      GLYPH_P:    seg = SEG_P;
      GLYPH_U:    seg = SEG_U;
      GLYPH_DASH: seg = SEG_DASH;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/zoe_scroller.sv
// Message scroller: shows one glyph of a rewritable message at a time, advancing
// on a prescaled tick while running or on a step edge while paused.
module zoe_scroller
  import zoe_pkg::*;
#(
  parameter int MAX_COUNT = 1000,
  parameter int MSG_LEN   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         dir,
  input  logic                         step,
  input  logic                         load,
  input  logic [GLYPH_W-1:0]           load_char,
  output logic [SEG_W-1:0]             seg,
  output logic                         dp,
  output logic [width_of(MSG_LEN)-1:0] idx
);

  localparam int IDX_W = width_of(MSG_LEN);
  localparam int CNT_W = width_of(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  logic [CNT_W-1:0] cnt;
  logic             step_q;
  logic [IDX_W-1:0] wr_ptr;
  glyph_t           msg_buf [MSG_LEN];
  seg_t             font_seg;
  logic             tick_adv;
  logic             step_adv;
  logic             advance;

  // The two advance sources need opposite run levels, so they never coincide.
  assign tick_adv = run && (cnt == CNT_LAST);
  assign step_adv = step && !step_q && !run;
  assign advance  = tick_adv || step_adv;

  zoe_font u_font (
    .code (msg_buf[idx]),
    .seg  (font_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      wr_ptr <= '0;
      step_q <= 1'b1;
      seg    <= SEG_BLANK;
      dp     <= 1'b0;
      // NOTE: the message is held in flops rather than RAM because reset must
      // restore the default text; a RAM macro could not be cleared in one edge.
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_buf[i] <= default_glyph(i);
      end
    end else begin
      // NOTE: all state here uses <= so every register sees pre-edge values,
      // which lets seg read the old idx while idx itself advances.
      step_q <= step;

      if (run) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end

      if (advance) begin
        if (dir) begin
          idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
        end else begin
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end

      if (load) begin
        msg_buf[wr_ptr] <= load_char;
        wr_ptr          <= (wr_ptr == IDX_LAST) ? '0 : wr_ptr + 1'b1;
      end

      seg <= font_seg;
      dp  <= (idx == '0);
    end
  end

endmodule

// File: tb/tb_zoe_scroller.sv
// Directed self-checking bench for zoe_scroller (main: MAX_COUNT=4/MSG_LEN=4,
// side: MAX_COUNT=1/MSG_LEN=3 for the every-clock and non-power-of-two wrap cases).
module tb_zoe_scroller;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       dir;
  logic       step;
  logic       load;
  logic [3:0] load_char;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] idx;
  logic [6:0] seg2;
  logic       dp2;
  logic [1:0] idx2;

  int checks = 0;
  int errors = 0;

  zoe_scroller #(.MAX_COUNT(4), .MSG_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .dir       (dir),
    .step      (step),
    .load      (load),
    .load_char (load_char),
    .seg       (seg),
    .dp        (dp),
    .idx       (idx)
  );

  zoe_scroller #(.MAX_COUNT(1), .MSG_LEN(3)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .dir       (dir),
    .step      (step),
    .load      (load),
    .load_char (load_char),
    .seg       (seg2),
    .dp        (dp2),
    .idx       (idx2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One step edge (advance on first clock), then check the glyph a clock later.
  task automatic step_once(input string tag, input logic [7:0] exp_seg);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check(tag, {1'b0, seg}, exp_seg);
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    load = 1'b1;
    load_char = a; tick();
    load_char = b; tick();
    load_char = c; tick();
    load_char = d; tick();
    load = 1'b0;
  endtask

  logic [7:0] run_seg  [4] = '{8'h5B, 8'h3F, 8'h79, 8'h00};
  logic [7:0] run_seg2 [3] = '{8'h5B, 8'h3F, 8'h79};

  initial begin
    reset = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0; load = 1'b0; load_char = 4'd0;
    repeat (3) tick();
    check("reset_seg", {1'b0, seg}, 8'h00);
    check("reset_dp", {7'b0, dp}, 8'h00);
    check("reset_idx", {6'b0, idx}, 8'h00);
    check("reset_seg2", {1'b0, seg2}, 8'h00);

    // Continuous run: each glyph shown for 4 clocks, wrap back to Z.
    reset = 1'b0; run = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check($sformatf("run_seg_e%0d", k), {1'b0, seg}, run_seg[((k - 1) / 4) % 4]);
      check($sformatf("run_dp_e%0d", k), {7'b0, dp}, {7'b0, (((k - 1) / 4) % 4) == 0});
      check($sformatf("run_idx_e%0d", k), {6'b0, idx}, 8'((k / 4) % 4));
      if (k <= 6) begin
        check($sformatf("mc1_seg_e%0d", k), {1'b0, seg2}, run_seg2[(k - 1) % 3]);
        check($sformatf("mc1_idx_e%0d", k), {6'b0, idx2}, 8'(k % 3));
      end
    end

    // Reverse from idx 0: 3,2,1,0, first shown glyph is blank.
    dir = 1'b1;
    repeat (3) tick();
    check("rev_idx3", {6'b0, idx}, 8'd3);
    tick();
    check("rev_seg_blank", {1'b0, seg}, 8'h00);
    repeat (3) tick();
    check("rev_idx2", {6'b0, idx}, 8'd2);
    repeat (4) tick();
    check("rev_idx1", {6'b0, idx}, 8'd1);
    repeat (4) tick();
    check("rev_idx0", {6'b0, idx}, 8'd0);
    tick();
    check("rev_seg_z", {1'b0, seg}, 8'h5B);
    check("rev_dp", {7'b0, dp}, 8'h01);

    // Pause with cnt=2, one short step pulse, then a 10-clock held step.
    tick();
    run = 1'b0; dir = 1'b0;
    step = 1'b1;
    tick();
    check("step1_idx", {6'b0, idx}, 8'd1);
    step = 1'b0;
    tick();
    check("step1_seg", {1'b0, seg}, 8'h3F);
    check("step1_dp", {7'b0, dp}, 8'h00);
    step = 1'b1;
    repeat (10) tick();
    check("step_hold_idx", {6'b0, idx}, 8'd2);
    step = 1'b0;
    tick();
    check("step_release_idx", {6'b0, idx}, 8'd2);
    run = 1'b1;
    tick();
    check("resume_no_adv", {6'b0, idx}, 8'd2);
    tick();
    check("resume_adv", {6'b0, idx}, 8'd3);
    run = 1'b0;

    // Load H,A,L,L then step through.
    load4(4'd7, 4'd4, 4'd8, 4'd8);
    step_once("load_h", 8'h76);
    check("load_h_dp", {7'b0, dp}, 8'h01);
    step_once("load_a", 8'h77);
    step_once("load_l0", 8'h38);
    step_once("load_l1", 8'h38);

    load4(4'd12, 4'd13, 4'd14, 4'd15);
    step_once("code12", 8'h00);
    step_once("code13", 8'h00);
    step_once("code14", 8'h00);
    step_once("code15", 8'h00);

    load4(4'd5, 4'd6, 4'd9, 4'd10);
    step_once("code_c", 8'h39);

    // Load into displayed entry 0 on the same edge as a step advance.
    load = 1'b1; load_char = 4'd11; step = 1'b1;
    tick();
    check("sim_idx", {6'b0, idx}, 8'd1);
    load = 1'b0; step = 1'b0;
    tick();
    check("sim_seg_f", {1'b0, seg}, 8'h71);
    dir = 1'b1;
    step_once("sim_seg_dash", 8'h40);
    check("sim_dp", {7'b0, dp}, 8'h01);
    dir = 1'b0;
    step_once("pre_rst_f", 8'h71);
    step_once("pre_rst_p", 8'h73);
    check("pre_rst_idx", {6'b0, idx}, 8'd2);

    // Reset with step held at idx 2: no advance after release, message restored.
    step = 1'b1; reset = 1'b1;
    tick();
    check("mid_rst_idx", {6'b0, idx}, 8'd0);
    check("mid_rst_seg", {1'b0, seg}, 8'h00);
    check("mid_rst_dp", {7'b0, dp}, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    check("rel_seg", {1'b0, seg}, 8'h5B);
    check("rel_dp", {7'b0, dp}, 8'h01);
    repeat (3) tick();
    check("rel_no_adv", {6'b0, idx}, 8'd0);
    step = 1'b0;
    tick();
    step_once("restored_o", 8'h3F);

    // Write pointer restarted at 0 after reset.
    load = 1'b1; load_char = 4'd9;
    tick();
    load = 1'b0;
    dir = 1'b1;
    step_once("wrptr_reset", 8'h73);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
